// File: rtl/sd_spi_master.sv
// SPI master engine for the SD-card path.
// Moves one DATA_W-bit word per accepted start, MSB first.
// Supports runtime slow/fast SCK divider, any CPOL/CPHA, NUM_CS selects
// and chip-select hold across words for multi-byte commands and bursts.
module sd_spi_master #(
   parameter int DATA_W   = 8,
   parameter int NUM_CS   = 1,
   parameter int DIV_SLOW = 125,
   parameter int DIV_FAST = 2,
   parameter bit CPOL     = 1'b0,
   parameter bit CPHA     = 1'b0,
   localparam int SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [SEL_W-1:0]  cs_sel,
   input  logic              fast,
   input  logic              hold_cs,
   input  logic              cs_release,
   output logic              busy,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam int EDGE_W  = $clog2(2 * DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q;
   logic                busy_q;
   logic                rx_valid_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic [DATA_W-1:0]   shreg_q;
   logic                sck_q;
   logic                mosi_q;
   logic [NUM_CS-1:0]   cs_n_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    div_m1_q;
   logic [EDGE_W-1:0]   edge_q;
   logic                hold_q;

   logic                wrap_d;
   logic                last_edge_d;
   logic                sample_edge_d;
   logic [NUM_CS-1:0]   cs_sel_n_d;

   // Active-low one-hot decode; an out-of-range index selects nothing.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_CS-1:0] dec;
      dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (sel == SEL_W'(i)) begin
            dec[i] = 1'b0;
         end else begin
            dec[i] = 1'b1;
         end
      end
      return dec;
   endfunction

   // Edge bookkeeping: wrap of the half-period counter, final edge, and
   // whether the upcoming edge samples miso (leading for CPHA=0, trailing for CPHA=1).
   always_comb begin
      wrap_d        = (cnt_q == div_m1_q);
      last_edge_d   = (edge_q == EDGE_W'(2 * DATA_W - 1));
      sample_edge_d = (~edge_q[0]) ^ CPHA;
      cs_sel_n_d    = cs_decode(cs_sel);
   end

   // Transfer FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         shreg_q    <= '0;
         sck_q      <= CPOL;
         mosi_q     <= 1'b1;
         cs_n_q     <= '1;
         cnt_q      <= '0;
         div_m1_q   <= '0;
         edge_q     <= '0;
         hold_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  shreg_q  <= tx_data;
                  hold_q   <= hold_cs;
                  div_m1_q <= fast ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
                  cnt_q    <= '0;
                  edge_q   <= '0;
                  busy_q   <= 1'b1;
                  // Selecting also drops any other select still held from earlier words.
                  cs_n_q   <= cs_sel_n_d;
                  // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for it.
                  mosi_q   <= CPHA ? 1'b1 : tx_data[DATA_W-1];
                  state_q  <= SHIFT;
               end else if (cs_release) begin
                  cs_n_q <= '1;
               end
            end
            SHIFT: begin
               if (wrap_d) begin
                  cnt_q  <= '0;
                  sck_q  <= ~sck_q;
                  edge_q <= edge_q + EDGE_W'(1);
                  if (sample_edge_d) begin
                     shreg_q <= {shreg_q[DATA_W-2:0], miso};
                  end else if (!last_edge_d) begin
                     // The final trailing edge in CPHA=0 has no further bit to present.
                     mosi_q <= shreg_q[DATA_W-1];
                  end
                  if (last_edge_d) begin
                     state_q <= DONE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               rx_data_q  <= shreg_q;
               rx_valid_q <= 1'b1;
               busy_q     <= 1'b0;
               mosi_q     <= 1'b1;
               if (!hold_q) begin
                  cs_n_q <= '1;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               sck_q   <= CPOL;
               mosi_q  <= 1'b1;
               cs_n_q  <= '1;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign sck      = sck_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: mode-0 two-select instance and a
// mode-3 single-select instance, with a receive scoreboard per instance.
module tb_sd_spi_master;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Mode 0 instance, two chip selects
   logic       start0 = 1'b0;
   logic [7:0] tx0 = 8'h00;
   logic       sel0 = 1'b0;
   logic       fast0 = 1'b0;
   logic       hold0 = 1'b0;
   logic       rel0 = 1'b0;
   logic       busy0, rv0, sck0, mosi0, miso0;
   logic [7:0] rxd0;
   logic [1:0] cs_n0;
   logic       loop0 = 1'b1;
   logic       miso_val0 = 1'b0;

   // Mode 3 instance, one chip select
   logic       start1 = 1'b0;
   logic [7:0] tx1 = 8'h00;
   logic       sel1 = 1'b0;
   logic       busy1, rv1, sck1, mosi1;
   logic       miso1 = 1'b0;
   logic [7:0] rxd1;
   logic [0:0] cs_n1;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   int rv_cnt0 = 0;
   int rv_cnt1 = 0;

   assign miso0 = loop0 ? mosi0 : miso_val0;

   always #5 clk = ~clk;

   sd_spi_master #(
      .DATA_W(8), .NUM_CS(2), .DIV_SLOW(125), .DIV_FAST(2), .CPOL(1'b0), .CPHA(1'b0)
   ) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .cs_sel(sel0),
      .fast(fast0), .hold_cs(hold0), .cs_release(rel0), .busy(busy0),
      .rx_data(rxd0), .rx_valid(rv0), .sck(sck0), .mosi(mosi0), .miso(miso0),
      .cs_n(cs_n0)
   );

   sd_spi_master #(
      .DATA_W(8), .NUM_CS(1), .DIV_SLOW(125), .DIV_FAST(2), .CPOL(1'b1), .CPHA(1'b1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .cs_sel(sel1),
      .fast(1'b1), .hold_cs(1'b0), .cs_release(1'b0), .busy(busy1),
      .rx_data(rxd1), .rx_valid(rv1), .sck(sck1), .mosi(mosi1), .miso(miso1),
      .cs_n(cs_n1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rx_valid pops the oldest expected word
   always @(posedge clk) begin
      #1;
      if (rv0 === 1'b1) begin
         rv_cnt0++;
         if (exp_q0.size() == 0) chk("rx0_unexpected_qsize", exp_q0.size(), 1);
         else chk("rx0_data", rxd0, exp_q0.pop_front());
      end
      if (rv1 === 1'b1) begin
         rv_cnt1++;
         if (exp_q1.size() == 0) chk("rx1_unexpected_qsize", exp_q1.size(), 1);
         else chk("rx1_data", rxd1, exp_q1.pop_front());
      end
   end

   // Mode-3 slave model: presents the next pattern bit on each leading (falling) edge
   logic [7:0] pat1 = 8'hC3;
   int lead1 = 0;
   always @(negedge sck1 or posedge start1) begin
      if (start1) lead1 = 0;
      else begin
         if (lead1 < 8) miso1 = pat1[7 - lead1];
         lead1++;
      end
   end

   // Mode-3 slave capture on trailing (rising) edges
   logic [7:0] slave_rx1 = 8'h00;
   always @(posedge sck1) slave_rx1 = {slave_rx1[6:0], mosi1};

   // mosi of the mode-3 instance may only move together with a falling SCK
   int mosi_chg1 = 0;
   int mosi_bad1 = 0;
   logic mosi1_p = 1'b1;
   logic sck1_p = 1'b1;
   always @(posedge clk) begin
      #1;
      if (busy1 === 1'b1 && mosi1 !== mosi1_p) begin
         mosi_chg1++;
         if (!(sck1_p === 1'b1 && sck1 === 1'b0)) mosi_bad1++;
      end
      mosi1_p = mosi1;
      sck1_p  = sck1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   // One mode-0 transfer: drives start, then watches every cycle until rx_valid.
   task automatic xfer0(input logic [7:0] tx, input logic [7:0] rxe, input logic sel,
                        input logic fst, input logic hld, input logic [1:0] cs_exp,
                        input int rep_at, input int rst_at,
                        output int lat, output int edges, output int cs_bad,
                        output int run_min, output int run_max);
      int   last_chg;
      logic sck_prev;
      @(negedge clk);
      tx0 = tx; sel0 = sel; fast0 = fst; hold0 = hld; start0 = 1'b1;
      exp_q0.push_back(rxe);
      @(posedge clk); #1;
      start0 = 1'b0;
      lat = -1; edges = 0; cs_bad = 0; run_min = 1000000; run_max = 0;
      last_chg = -1;
      sck_prev = sck0;
      for (int c = 1; c < 5000; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (sck0 !== sck_prev) begin
            edges++;
            if (last_chg >= 0) begin
               if (c - last_chg < run_min) run_min = c - last_chg;
               if (c - last_chg > run_max) run_max = c - last_chg;
            end
            last_chg = c;
         end
         sck_prev = sck0;
         if (rv0 === 1'b1) begin lat = c; break; end
         if (cs_n0 !== cs_exp) cs_bad++;
         start0 = (c == rep_at) ? 1'b1 : 1'b0;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_mid_sck", sck0, 0);
            chk("rst_mid_mosi", mosi0, 1);
            chk("rst_mid_cs_n", cs_n0, 2'b11);
            chk("rst_mid_busy", busy0, 0);
            chk("rst_mid_rx_valid", rv0, 0);
            break;
         end
      end
   endtask

   initial begin
      int lat, edges, cs_bad, rmin, rmax, snap, lat1;

      // Reset values
      #12;
      chk("rst_busy", busy0, 0);
      chk("rst_rx_valid", rv0, 0);
      chk("rst_rx_data", rxd0, 0);
      chk("rst_sck0", sck0, 0);
      chk("rst_mosi0", mosi0, 1);
      chk("rst_cs_n0", cs_n0, 2'b11);
      chk("rst_sck1_cpol1", sck1, 1);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);

      // Mode 0 fast, loopback 0xA5
      loop0 = 1'b1;
      xfer0(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 2'b10, 0, 0, lat, edges, cs_bad, rmin, rmax);
      chk("a5_latency", lat, 34);
      chk("a5_edges", edges, 16);
      chk("a5_cs_low_1_33", cs_bad, 0);
      chk("a5_cs_high_34", cs_n0, 2'b11);
      chk("a5_busy_34", busy0, 0);
      chk("a5_half_min", rmin, 2);
      chk("a5_half_max", rmax, 2);

      // Slow divider, tx 0xFF, miso held low
      loop0 = 1'b0; miso_val0 = 1'b0;
      xfer0(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10, 0, 0, lat, edges, cs_bad, rmin, rmax);
      chk("slow_latency", lat, 2002);
      chk("slow_edges", edges, 16);
      chk("slow_half_min", rmin, 125);
      chk("slow_half_max", rmax, 125);
      chk("slow_cs", cs_bad, 0);

      // Burst on select 1 with hold, second word issued at rx_valid
      loop0 = 1'b1;
      xfer0(8'h40, 8'h40, 1'b1, 1'b1, 1'b1, 2'b01, 0, 0, lat, edges, cs_bad, rmin, rmax);
      chk("burst1_latency", lat, 34);
      chk("burst1_cs", cs_bad, 0);
      chk("burst1_cs_held", cs_n0, 2'b01);
      xfer0(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 2'b01, 0, 0, lat, edges, cs_bad, rmin, rmax);
      chk("burst2_latency", lat, 34);
      chk("burst2_cs", cs_bad, 0);
      chk("burst2_cs_held", cs_n0, 2'b01);
      @(negedge clk); rel0 = 1'b1;
      @(posedge clk); #1;
      chk("cs_release", cs_n0, 2'b11);
      rel0 = 1'b0;

      // start re-pulsed while busy is ignored
      snap = rv_cnt0;
      xfer0(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 2'b10, 10, 0, lat, edges, cs_bad, rmin, rmax);
      chk("repulse_latency", lat, 34);
      repeat (50) @(posedge clk);
      #1;
      chk("repulse_one_rx_valid", rv_cnt0 - snap, 1);

      // Reset at cycle 15 aborts, then a fresh 0x3C completes
      snap = rv_cnt0;
      xfer0(8'h96, 8'h96, 1'b0, 1'b1, 1'b0, 2'b10, 0, 15, lat, edges, cs_bad, rmin, rmax);
      repeat (2) @(posedge clk);
      exp_q0.delete();
      @(negedge clk); rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("rst_no_rx_valid", rv_cnt0 - snap, 0);
      xfer0(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 2'b10, 0, 0, lat, edges, cs_bad, rmin, rmax);
      chk("post_rst_latency", lat, 34);
      chk("post_rst_edges", edges, 16);

      // Mode 3: slave drives 0xC3, master sends 0x5A
      @(negedge clk);
      tx1 = 8'h5A; start1 = 1'b1;
      exp_q1.push_back(8'hC3);
      @(posedge clk); #1;
      start1 = 1'b0;
      lat1 = -1;
      for (int c = 1; c < 200; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (rv1 === 1'b1) begin lat1 = c; break; end
      end
      chk("m3_latency", lat1, 34);
      chk("m3_slave_rx", slave_rx1, 8'h5A);
      chk("m3_mosi_off_falling", mosi_bad1, 0);
      chk("m3_mosi_changes", mosi_chg1, 7);
      chk("m3_sck_idle_high", sck1, 1);
      chk("m3_mosi_idle_high", mosi1, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb0_empty", exp_q0.size(), 0);
      chk("sb1_empty", exp_q1.size(), 0);
      chk("rv1_count", rv_cnt1, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
